code25_source: RTL
==================

# code25_source

Sequential source stage for the 2-of-5 display path. It holds a decimal digit 0–9, steps it up or down from a push button, or loads it from BCD switches. It presents the digit as registered 2-of-5 code lines E1..E5 to the downstream per-segment decoders (SegmentoA…G). It rejects out-of-range BCD loads and flags them.

## Interface
Parameters:
- DEB_CYCLES, 16, consecutive synchronized-stable cycles required before a button level is accepted; only used with the debounce feature; legal range 2–65535.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- step_btn  in  1  raw push button, asynchronous to clk, active-high.
- up  in  1  step direction: 1 = increment, 0 = decrement; sampled on the cycle the step pulse is generated.
- load  in  1  synchronous load request, sampled every edge.
- bcd_in  in  4  BCD value for load.
- E1, E2, E3, E4, E5  out  1 each  registered 2-of-5 code of the current digit.
- digit  out  4  registered current digit, binary 0–9.
- err  out  1  sticky flag: an invalid BCD load was attempted.
- upd  out  1  one-cycle pulse: the digit and code were written this cycle.

## Operation
- Code map, written as E1E2E3E4E5:
  - 0 = 11000, 1 = 00011, 2 = 00101, 3 = 00110, 4 = 01001
  - 5 = 01010, 6 = 01100, 7 = 10001, 8 = 10010, 9 = 10100
- Exactly two of E1..E5 are high whenever rst_n is high and reset has been applied once.
- Button path:
  - 2-FF synchronizer, then optional debouncer, then rising-edge detector.
  - The edge detector produces step_p, one cycle wide per press.
  - A held button produces no further steps.
- Priority each cycle: reset, then load, then step_p.
- Valid load (load=1, bcd_in ≤ 9):
  - digit ← bcd_in, code updated, err ← 0, upd ← 1.
  - A coincident step_p is discarded, not deferred.
- Invalid load (load=1, bcd_in 10–15):
  - digit and code unchanged, err ← 1, upd ← 0.
  - A coincident step_p is also discarded.
- Step (step_p=1, load=0):
  - up=1: 9 wraps to 0, otherwise +1.
  - up=0: 0 wraps to 9, otherwise −1.
  - upd ← 1; err unchanged.
- err is cleared only by reset or a valid load.
- Reset values:
  - digit = 0 and E1..E5 = 11000.
  - err = 0, upd = 0.
  - Synchronizer, edge and debounce registers = 0.
- Because reset clears the edge detector's history, a button held through reset release causes one step once the synchronized level is first seen high.

## Timing
- digit, E1..E5, err and upd are all registered and change only on the same edge. There is no combinational path from any input to any output.
- Load latency: load sampled at edge k, outputs updated at edge k, visible for the cycle after k.
- Step latency without debounce: step_btn first sampled high at edge k, outputs updated at edge k+2.
- Step latency with debounce: the synchronized level must stay high for DEB_CYCLES consecutive edges, then outputs update one edge later. The same rule applies to release.
- upd is high for exactly one cycle per write. Consecutive valid loads give consecutive upd pulses.
- Reset mid-debounce discards the partial count.

## Configuration
- CODE25_DEBOUNCE_EN defined:
  - A counter of width ceil(log2(DEB_CYCLES+1)) filters the synchronized button.
  - The counter reloads on every change of the synchronized level.
  - The filtered level toggles only after DEB_CYCLES stable cycles.
- Not defined:
  - The synchronized level feeds the edge detector directly.
  - DEB_CYCLES is ignored and no counter is instantiated.

## Test plan
- Reset then idle: digit=0, E=11000, err=0, upd=0. Assert rst_n low mid-count from digit 7: the next edge returns digit=0, E=11000.
- 10 step presses with up=1 from 0: digit sequence 1..9,0 with codes 00011…10100, 11000, and exactly 10 upd pulses. Repeat with up=0: 9,8,…,0.
- load=1, bcd_in=12 at digit 5: digit stays 5, err=1, upd=0. Then load bcd_in=3: digit=3, E=00110, err=0, upd=1.
- load (bcd_in=8) on the same edge as step_p: digit=8, no extra step follows. Button held high 50 cycles: exactly one step.
- Without CODE25_DEBOUNCE_EN: button sampled at edge k gives the update at edge k+2.
- With CODE25_DEBOUNCE_EN and DEB_CYCLES=4:
  - Glitch of 3 cycles high: no step.
  - 4 stable cycles: one step.
  - Bounce 1-0-1 then stable: one step, timed from the last transition.

Source files
------------

// File: rtl/code25_source_if.sv
// code25_source_if: groups the button/load inputs and the 2-of-5 digit outputs
// of the code25_source stage. The master drives the controls and the slave
// (the source stage) drives the registered code and status.
interface code25_source_if;
  logic       step_btn;
  logic       up;
  logic       load;
  logic [3:0] bcd_in;
  logic       E1;
  logic       E2;
  logic       E3;
  logic       E4;
  logic       E5;
  logic [3:0] digit;
  logic       err;
  logic       upd;

  modport master (
    output step_btn, up, load, bcd_in,
    input  E1, E2, E3, E4, E5, digit, err, upd
  );

  modport slave (
    input  step_btn, up, load, bcd_in,
    output E1, E2, E3, E4, E5, digit, err, upd
  );
endinterface

// File: rtl/code25_source.sv
// code25_source: holds a decimal digit 0-9, steps it from a push button or
// loads it from BCD switches, and presents it as a registered 2-of-5 code.
// Optional button debouncer enabled by defining CODE25_DEBOUNCE_EN.
module code25_source #(
  parameter int DEB_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  code25_source_if.slave bus
);

  logic       sync1_d, sync1_q;
  logic       sync2_d, sync2_q;
  logic       lvl;
  logic       prev_d, prev_q;
  logic       step_p;
  logic [3:0] digit_d, digit_q;
  logic [4:0] code_d, code_q;
  logic       err_d, err_q;
  logic       upd_d, upd_q;

  // 2-of-5 code of a digit, bit 4 = E1 ... bit 0 = E5
  function automatic logic [4:0] code25(input logic [3:0] d);
    logic [4:0] c;
    case (d)
      4'd0:    c = 5'b11000;
      4'd1:    c = 5'b00011;
      4'd2:    c = 5'b00101;
      4'd3:    c = 5'b00110;
      4'd4:    c = 5'b01001;
      4'd5:    c = 5'b01010;
      4'd6:    c = 5'b01100;
      4'd7:    c = 5'b10001;
      4'd8:    c = 5'b10010;
      4'd9:    c = 5'b10100;
      default: c = 5'b11000;
    endcase
    return c;
  endfunction

  // Modulo-10 step in either direction
  function automatic logic [3:0] step_next(input logic [3:0] d, input logic dir);
    logic [3:0] n;
    if (dir) n = (d >= 4'd9) ? 4'd0 : d + 4'd1;
    else     n = (d == 4'd0) ? 4'd9 : d - 4'd1;
    return n;
  endfunction

  // Two-stage synchronizer for the asynchronous button
  always_comb begin
    sync1_d = bus.step_btn;
    sync2_d = sync1_q;
  end

  // Synchronizer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef CODE25_DEBOUNCE_EN
  localparam int CntW = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            filt_d, filt_q;

  // Count consecutive cycles the synchronized level disagrees with the
  // filtered level; any return to agreement restarts the count.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CntLast) filt_d = sync2_q;
      else                  cnt_d  = cnt_q + 1'b1;
    end
  end

  // Debounce counter and filtered level registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign lvl = filt_q;
`else
  logic unused_deb;
  assign unused_deb = (DEB_CYCLES > 0);
  assign lvl        = sync2_q;
`endif

  // Rising-edge detector: one step pulse per press
  always_comb begin
    prev_d = lvl;
    step_p = lvl & ~prev_q;
  end

  // Edge detector history register
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  // Digit update: load beats step; a step coincident with any load is dropped
  always_comb begin
    digit_d = digit_q;
    code_d  = code_q;
    err_d   = err_q;
    upd_d   = 1'b0;
    if (bus.load) begin
      if (bus.bcd_in <= 4'd9) begin
        digit_d = bus.bcd_in;
        code_d  = code25(bus.bcd_in);
        err_d   = 1'b0;
        upd_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (step_p) begin
      digit_d = step_next(digit_q, bus.up);
      code_d  = code25(digit_d);
      upd_d   = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_q <= 4'd0;
      code_q  <= 5'b11000;
      err_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      digit_q <= digit_d;
      code_q  <= code_d;
      err_q   <= err_d;
      upd_q   <= upd_d;
    end
  end

  assign bus.digit = digit_q;
  assign bus.E1    = code_q[4];
  assign bus.E2    = code_q[3];
  assign bus.E3    = code_q[2];
  assign bus.E4    = code_q[1];
  assign bus.E5    = code_q[0];
  assign bus.err   = err_q;
  assign bus.upd   = upd_q;

endmodule
